// File: rtl/baser_seq_pkg.sv
// Shared types and the fixed 14-step program for the BASE-R test sequencer.
package baser_seq_pkg;

   localparam int unsigned NUM_STEPS = 14;
   localparam int unsigned STEP_W    = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DUT_RST,
      ST_SETTLE,
      ST_SNAP,
      ST_DWELL,
      ST_EVAL,
      ST_DONE
   } state_t;

   typedef struct packed {
      logic        enable;
      logic [1:0]  valid;
      logic [3:0]  data_sel;
      logic [7:0]  txc;
      logic [63:0] txd;
   } step_t;

   // Steps 0..6 use the generator's internal patterns, 7..13 feed MII words.
   localparam step_t STEP_TABLE [NUM_STEPS] = '{
      '{1'b1, 2'b11, 4'b0000, 8'h00, 64'h0000_0000_0000_0000},
      '{1'b1, 2'b11, 4'b0001, 8'h00, 64'h0000_0000_0000_0000},
      '{1'b1, 2'b11, 4'b0010, 8'h00, 64'h0000_0000_0000_0000},
      '{1'b1, 2'b11, 4'b0011, 8'h00, 64'h0000_0000_0000_0000},
      '{1'b1, 2'b11, 4'b0100, 8'h00, 64'h0000_0000_0000_0000},
      '{1'b1, 2'b11, 4'b1000, 8'h00, 64'h0000_0000_0000_0000},
      '{1'b1, 2'b11, 4'b1111, 8'h00, 64'h0000_0000_0000_0000},
      '{1'b0, 2'b11, 4'b0000, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF},
      '{1'b0, 2'b11, 4'b0000, 8'h00, 64'hAAAA_AAAA_AAAA_AAAA},
      '{1'b0, 2'b11, 4'b0000, 8'hFF, 64'h0707_0707_0707_07FD},
      '{1'b0, 2'b11, 4'b0000, 8'h01, 64'hAAAA_AAAA_AAAA_AAFB},
      '{1'b0, 2'b11, 4'b0000, 8'h00, 64'hAAAA_AAAA_AAAA_AAAA},
      '{1'b0, 2'b11, 4'b0000, 8'hFC, 64'h0707_0707_07FD_AAAA},
      '{1'b0, 2'b11, 4'b0000, 8'hFF, 64'h0707_0707_0707_0707}
   };

endpackage

// File: rtl/baser_seq_delta_check.sv
// Per-step counter delta evaluation: modulo deltas, pass/fail and saturating error total.
module baser_seq_delta_check
   import baser_seq_pkg::*;
#(
   parameter int unsigned CNT_WIDTH  = 32,
   parameter int unsigned MIN_BLOCKS = 4
) (
   input  logic [CNT_WIDTH-1:0] i_blk_snap,
   input  logic [CNT_WIDTH-1:0] i_inv_snap,
   input  logic [CNT_WIDTH-1:0] i_blk_count,
   input  logic [CNT_WIDTH-1:0] i_inv_count,
   input  logic [CNT_WIDTH-1:0] i_err_total,
   output logic                 o_fail_c,
   output logic [CNT_WIDTH-1:0] o_err_total_c
);

   logic [CNT_WIDTH-1:0] w_d_blk;
   logic [CNT_WIDTH-1:0] w_d_inv;
   logic [CNT_WIDTH:0]   w_sum;

   // Plain subtraction wraps, so a counter rollover still yields the true delta.
   assign w_d_blk = i_blk_count - i_blk_snap;
   assign w_d_inv = i_inv_count - i_inv_snap;
   assign w_sum   = {1'b0, i_err_total} + {1'b0, w_d_inv};

   assign o_fail_c      = (w_d_inv != '0) || (w_d_blk < CNT_WIDTH'(MIN_BLOCKS));
   assign o_err_total_c = w_sum[CNT_WIDTH] ? '1 : w_sum[CNT_WIDTH-1:0];

endmodule

// File: rtl/baser_test_sequencer.sv
// Drives the PCS generator/checker chain through the fixed step program and grades each step.
// Optional: define BASER_SEQ_STOP_ON_FAIL_EN to end the program at the first failing step.
module baser_test_sequencer
   import baser_seq_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 8,
   parameter int unsigned MIN_BLOCKS    = 4,
   parameter int unsigned CNT_WIDTH     = 32,
   parameter int unsigned DWELL_WIDTH   = 16
) (
   input  logic                   clk,
   input  logic                   i_rst,
   input  logic                   i_start,
   input  logic                   i_abort,
   input  logic [DWELL_WIDTH-1:0] i_dwell,
   input  logic [CNT_WIDTH-1:0]   i_blk_count,
   input  logic [CNT_WIDTH-1:0]   i_inv_count,
   output logic                   o_gen_rst,
   output logic                   o_gen_enable,
   output logic [1:0]             o_gen_valid,
   output logic [3:0]             o_data_sel,
   output logic [63:0]            o_txd,
   output logic [7:0]             o_txc,
   output logic [3:0]             o_step,
   output logic                   o_busy,
   output logic                   o_done,
   output logic                   o_pass,
   output logic [NUM_STEPS-1:0]   o_fail_mask,
   output logic [CNT_WIDTH-1:0]   o_err_total
);

   localparam int unsigned DUT_RST_CYCLES = 4;

   state_t                 r_state;
   logic [DWELL_WIDTH-1:0] r_cnt;
   logic [DWELL_WIDTH-1:0] r_dwell;
   logic [CNT_WIDTH-1:0]   r_blk_snap;
   logic [CNT_WIDTH-1:0]   r_inv_snap;
   logic                   r_gen_rst;
   logic                   r_gen_enable;
   logic [1:0]             r_gen_valid;
   logic [3:0]             r_data_sel;
   logic [63:0]            r_txd;
   logic [7:0]             r_txc;
   logic [3:0]             r_step;
   logic                   r_busy;
   logic                   r_done;
   logic                   r_pass;
   logic [NUM_STEPS-1:0]   r_fail_mask;
   logic [CNT_WIDTH-1:0]   r_err_total;

   state_t                 w_state_nxt;
   logic [DWELL_WIDTH-1:0] w_cnt_nxt;
   logic [DWELL_WIDTH-1:0] w_dwell_nxt;
   logic [CNT_WIDTH-1:0]   w_blk_snap_nxt;
   logic [CNT_WIDTH-1:0]   w_inv_snap_nxt;
   logic [3:0]             w_step_nxt;
   logic                   w_pass_nxt;
   logic [NUM_STEPS-1:0]   w_mask_nxt;
   logic [CNT_WIDTH-1:0]   w_err_nxt;
   logic                   w_gen_rst_nxt;
   logic                   w_load_step;
   logic                   w_clr_gen;
   logic                   w_fail;
   logic [CNT_WIDTH-1:0]   w_err_sum;
   step_t                  w_entry;

   baser_seq_delta_check #(
      .CNT_WIDTH  (CNT_WIDTH),
      .MIN_BLOCKS (MIN_BLOCKS)
   ) u_delta_check (
      .i_blk_snap    (r_blk_snap),
      .i_inv_snap    (r_inv_snap),
      .i_blk_count   (i_blk_count),
      .i_inv_count   (i_inv_count),
      .i_err_total   (r_err_total),
      .o_fail_c      (w_fail),
      .o_err_total_c (w_err_sum)
   );

   assign w_entry = STEP_TABLE[w_step_nxt];

   // Next-state and next-register values; abort overrides everything at the end.
   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_dwell_nxt    = r_dwell;
      w_blk_snap_nxt = r_blk_snap;
      w_inv_snap_nxt = r_inv_snap;
      w_step_nxt     = r_step;
      w_pass_nxt     = r_pass;
      w_mask_nxt     = r_fail_mask;
      w_err_nxt      = r_err_total;
      w_load_step    = 1'b0;
      w_clr_gen      = 1'b0;
      w_gen_rst_nxt  = r_gen_rst;

      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (i_start) begin
               w_dwell_nxt = (i_dwell == '0) ? DWELL_WIDTH'(1) : i_dwell;
               w_mask_nxt  = '0;
               w_err_nxt   = '0;
               w_step_nxt  = '0;
               w_cnt_nxt   = '0;
               w_pass_nxt  = 1'b0;
               w_clr_gen   = 1'b1;
               w_state_nxt = ST_DUT_RST;
            end
         end
         ST_DUT_RST: begin
            if (r_cnt == DWELL_WIDTH'(DUT_RST_CYCLES - 1)) begin
               w_cnt_nxt   = '0;
               w_load_step = 1'b1;
               w_state_nxt = ST_SETTLE;
            end else begin
               w_cnt_nxt = r_cnt + DWELL_WIDTH'(1);
            end
         end
         ST_SETTLE: begin
            if (r_cnt == DWELL_WIDTH'(SETTLE_CYCLES - 1)) begin
               w_cnt_nxt   = '0;
               w_state_nxt = ST_SNAP;
            end else begin
               w_cnt_nxt = r_cnt + DWELL_WIDTH'(1);
            end
         end
         ST_SNAP: begin
            w_blk_snap_nxt = i_blk_count;
            w_inv_snap_nxt = i_inv_count;
            w_cnt_nxt      = '0;
            w_state_nxt    = ST_DWELL;
         end
         ST_DWELL: begin
            if (r_cnt == r_dwell - DWELL_WIDTH'(1)) begin
               w_cnt_nxt   = '0;
               w_state_nxt = ST_EVAL;
            end else begin
               w_cnt_nxt = r_cnt + DWELL_WIDTH'(1);
            end
         end
         ST_EVAL: begin
            w_err_nxt  = w_err_sum;
            w_mask_nxt = r_fail_mask | (NUM_STEPS'(w_fail) << r_step);
`ifdef BASER_SEQ_STOP_ON_FAIL_EN
            if (w_fail || (r_step == 4'(NUM_STEPS - 1))) begin
`else
            if (r_step == 4'(NUM_STEPS - 1)) begin
`endif
               w_pass_nxt  = (w_mask_nxt == '0);
               w_state_nxt = ST_DONE;
            end else begin
               w_step_nxt  = r_step + 4'd1;
               w_load_step = 1'b1;
               w_state_nxt = ST_SETTLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase

      if (i_abort) begin
         w_state_nxt    = ST_DONE;
         w_cnt_nxt      = r_cnt;
         w_dwell_nxt    = r_dwell;
         w_blk_snap_nxt = r_blk_snap;
         w_inv_snap_nxt = r_inv_snap;
         w_step_nxt     = r_step;
         w_mask_nxt     = r_fail_mask;
         w_err_nxt      = r_err_total;
         w_pass_nxt     = 1'b0;
         w_load_step    = 1'b0;
         w_clr_gen      = 1'b0;
      end

      if (w_state_nxt == ST_DUT_RST) begin
         w_gen_rst_nxt = 1'b1;
      end else if (w_state_nxt == ST_SETTLE) begin
         w_gen_rst_nxt = 1'b0;
      end
   end

   // All state and outputs register here; generator fields change only on step load or restart.
   always_ff @(posedge clk) begin
      if (i_rst) begin
         r_state      <= ST_IDLE;
         r_cnt        <= '0;
         r_dwell      <= DWELL_WIDTH'(1);
         r_blk_snap   <= '0;
         r_inv_snap   <= '0;
         r_gen_rst    <= 1'b1;
         r_gen_enable <= 1'b0;
         r_gen_valid  <= '0;
         r_data_sel   <= '0;
         r_txd        <= '0;
         r_txc        <= '0;
         r_step       <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_pass       <= 1'b0;
         r_fail_mask  <= '0;
         r_err_total  <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_dwell     <= w_dwell_nxt;
         r_blk_snap  <= w_blk_snap_nxt;
         r_inv_snap  <= w_inv_snap_nxt;
         r_gen_rst   <= w_gen_rst_nxt;
         r_step      <= w_step_nxt;
         r_busy      <= (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_DONE);
         r_done      <= (w_state_nxt == ST_DONE);
         r_pass      <= w_pass_nxt;
         r_fail_mask <= w_mask_nxt;
         r_err_total <= w_err_nxt;
         if (w_load_step) begin
            r_gen_enable <= w_entry.enable;
            r_gen_valid  <= w_entry.valid;
            r_data_sel   <= w_entry.data_sel;
            r_txd        <= w_entry.txd;
            r_txc        <= w_entry.txc;
         end else if (w_clr_gen) begin
            r_gen_enable <= 1'b0;
            r_gen_valid  <= '0;
            r_data_sel   <= '0;
            r_txd        <= '0;
            r_txc        <= '0;
         end
      end
   end

   assign o_gen_rst    = r_gen_rst;
   assign o_gen_enable = r_gen_enable;
   assign o_gen_valid  = r_gen_valid;
   assign o_data_sel   = r_data_sel;
   assign o_txd        = r_txd;
   assign o_txc        = r_txc;
   assign o_step       = r_step;
   assign o_busy       = r_busy;
   assign o_done       = r_done;
   assign o_pass       = r_pass;
   assign o_fail_mask  = r_fail_mask;
   assign o_err_total  = r_err_total;

endmodule

// File: tb/tb_baser_test_sequencer.sv
// Directed bench for baser_test_sequencer with a simple counter model standing in for the checker.
module tb_baser_test_sequencer;

   logic        clk;
   logic        i_rst;
   logic        i_start;
   logic        i_abort;
   logic [15:0] i_dwell;
   logic [31:0] blk_cnt;
   logic [31:0] inv_cnt;
   logic        o_gen_rst;
   logic        o_gen_enable;
   logic [1:0]  o_gen_valid;
   logic [3:0]  o_data_sel;
   logic [63:0] o_txd;
   logic [7:0]  o_txc;
   logic [3:0]  o_step;
   logic        o_busy;
   logic        o_done;
   logic        o_pass;
   logic [13:0] o_fail_mask;
   logic [31:0] o_err_total;

   int          total = 0;
   int          bad   = 0;
   int          ncyc;

   // counter model controls
   logic        cnt_load = 1'b0;
   logic [31:0] cnt_init = 32'h0;
   logic [31:0] inc      = 32'd1;
   logic        freeze2  = 1'b0;
   logic        inject9  = 1'b0;
   logic [3:0]  prev_step = 4'hF;
   int          stepcyc  = 0;

   baser_test_sequencer dut (
      .clk         (clk),
      .i_rst       (i_rst),
      .i_start     (i_start),
      .i_abort     (i_abort),
      .i_dwell     (i_dwell),
      .i_blk_count (blk_cnt),
      .i_inv_count (inv_cnt),
      .o_gen_rst   (o_gen_rst),
      .o_gen_enable(o_gen_enable),
      .o_gen_valid (o_gen_valid),
      .o_data_sel  (o_data_sel),
      .o_txd       (o_txd),
      .o_txc       (o_txc),
      .o_step      (o_step),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_pass      (o_pass),
      .o_fail_mask (o_fail_mask),
      .o_err_total (o_err_total)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Checker stand-in: counters move on the falling edge so they are stable at each rising edge.
   always @(negedge clk) begin
      if (cnt_load) begin
         blk_cnt = cnt_init;
         inv_cnt = 32'h0;
      end else begin
         if (!(freeze2 && o_busy && o_step == 4'd2))
            blk_cnt = blk_cnt + inc;
         if (o_step != prev_step) stepcyc = 0;
         else stepcyc = stepcyc + 1;
         prev_step = o_step;
         if (inject9 && o_busy && o_step == 4'd9 && stepcyc >= 20 && stepcyc <= 22)
            inv_cnt = inv_cnt + 32'd1;
      end
   end

   function automatic logic [78:0] exp_entry(input int k);
      case (k)
         0:  return {1'b1, 2'b11, 4'b0000, 8'h00, 64'h0};
         1:  return {1'b1, 2'b11, 4'b0001, 8'h00, 64'h0};
         2:  return {1'b1, 2'b11, 4'b0010, 8'h00, 64'h0};
         3:  return {1'b1, 2'b11, 4'b0011, 8'h00, 64'h0};
         4:  return {1'b1, 2'b11, 4'b0100, 8'h00, 64'h0};
         5:  return {1'b1, 2'b11, 4'b1000, 8'h00, 64'h0};
         6:  return {1'b1, 2'b11, 4'b1111, 8'h00, 64'h0};
         7:  return {1'b0, 2'b11, 4'b0000, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF};
         8:  return {1'b0, 2'b11, 4'b0000, 8'h00, 64'hAAAA_AAAA_AAAA_AAAA};
         9:  return {1'b0, 2'b11, 4'b0000, 8'hFF, 64'h0707_0707_0707_07FD};
         10: return {1'b0, 2'b11, 4'b0000, 8'h01, 64'hAAAA_AAAA_AAAA_AAFB};
         11: return {1'b0, 2'b11, 4'b0000, 8'h00, 64'hAAAA_AAAA_AAAA_AAAA};
         12: return {1'b0, 2'b11, 4'b0000, 8'hFC, 64'h0707_0707_07FD_AAAA};
         13: return {1'b0, 2'b11, 4'b0000, 8'hFF, 64'h0707_0707_0707_0707};
         default: return '0;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      i_rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      i_rst = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_gen"}, 80'({o_gen_rst, o_gen_enable, o_gen_valid, o_data_sel, o_txc}),
          80'({1'b1, 1'b0, 2'b00, 4'h0, 8'h00}));
      chk({tag, "_txd"}, 80'(o_txd), 80'h0);
      chk({tag, "_stat"}, 80'({o_step, o_busy, o_done, o_pass, o_fail_mask}), 80'h0);
      chk({tag, "_err"}, 80'(o_err_total), 80'h0);
   endtask

   // Pulse start; caller is at a falling edge with the DUT idle or done.
   task automatic start_run(input logic [15:0] dwell);
      i_dwell = dwell;
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
   endtask

   // Count rising edges after the start edge until done; optionally grade the step table.
   task automatic wait_done(input bit check_table, output int n);
      int last;
      last = -1;
      n = 0;
      chk("run_busy_in_dut_rst", 80'({o_busy, o_gen_rst, o_done}), 80'({1'b1, 1'b1, 1'b0}));
      while (!o_done && n < 3000) begin
         @(negedge clk);
         n++;
         if (check_table && o_busy && !o_gen_rst && int'(o_step) != last) begin
            last = int'(o_step);
            chk($sformatf("table_step%0d", o_step),
                80'({o_gen_enable, o_gen_valid, o_data_sel, o_txc, o_txd}),
                80'(exp_entry(int'(o_step))));
         end
      end
      chk("done_reached", 80'(o_done), 80'(1));
   endtask

   task automatic wait_step(input logic [3:0] k);
      int n;
      n = 0;
      while (o_step != k && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("wait_step", 80'(o_step), 80'(k));
   endtask

   initial begin
      i_rst   = 1'b1;
      i_start = 1'b0;
      i_abort = 1'b0;
      i_dwell = 16'd60;
      blk_cnt = 32'h0;
      inv_cnt = 32'h0;

      do_reset();
      check_reset_values("reset");

      // Clean run: 4 + 14*(8+1+60+1) = 984 edges to DONE.
      start_run(16'd60);
      wait_done(1'b1, ncyc);
      chk("clean_cycles", 80'(ncyc), 80'(984));
      chk("clean_result", 80'({o_pass, o_busy, o_step, o_fail_mask}), 80'({1'b1, 1'b0, 4'd13, 14'h0}));
      chk("clean_err", 80'(o_err_total), 80'h0);
      chk("clean_hold_gen", 80'({o_gen_enable, o_txc, o_txd}), 80'({1'b0, 8'hFF, 64'h0707_0707_0707_0707}));

      // Three invalid blocks during step 9's dwell; restart from DONE.
      inject9 = 1'b1;
      start_run(16'd60);
      wait_done(1'b0, ncyc);
      inject9 = 1'b0;
      chk("inv_mask", 80'(o_fail_mask), 80'(14'h0200));
      chk("inv_err", 80'(o_err_total), 80'd3);
      chk("inv_pass", 80'(o_pass), 80'(0));
`ifdef BASER_SEQ_STOP_ON_FAIL_EN
      chk("inv_step", 80'(o_step), 80'd9);
`else
      chk("inv_step", 80'(o_step), 80'd13);
`endif

      // Block counter frozen in step 2; error total must be cleared by the restart.
      freeze2 = 1'b1;
      start_run(16'd60);
      wait_done(1'b0, ncyc);
      freeze2 = 1'b0;
      chk("frz_mask", 80'(o_fail_mask), 80'(14'h0004));
      chk("frz_err_cleared", 80'(o_err_total), 80'h0);
      chk("frz_pass", 80'(o_pass), 80'(0));
`ifdef BASER_SEQ_STOP_ON_FAIL_EN
      chk("frz_step", 80'(o_step), 80'd2);
`else
      chk("frz_step", 80'(o_step), 80'd13);
`endif

      // MIN_BLOCKS boundary: delta = dwell+1 blocks at one block per cycle.
      start_run(16'd3);
      wait_done(1'b0, ncyc);
      chk("dwell3_pass", 80'({o_pass, o_fail_mask}), 80'({1'b1, 14'h0}));
      start_run(16'd2);
      wait_done(1'b0, ncyc);
`ifdef BASER_SEQ_STOP_ON_FAIL_EN
      chk("dwell2_fail", 80'({o_pass, o_step, o_fail_mask}), 80'({1'b0, 4'd0, 14'h0001}));
`else
      chk("dwell2_fail", 80'({o_pass, o_step, o_fail_mask}), 80'({1'b0, 4'd13, 14'h3FFF}));
`endif

      // dwell 0 acts as 1: 4 + 14*11 = 158 edges; two blocks per cycle gives exactly 4.
      inc = 32'd2;
      start_run(16'd0);
      wait_done(1'b0, ncyc);
      inc = 32'd1;
      chk("dwell0_cycles", 80'(ncyc), 80'(158));
      chk("dwell0_pass", 80'({o_pass, o_fail_mask}), 80'({1'b1, 14'h0}));

      // Counter wrap: start near all-ones so it rolls over inside step 3's dwell.
      @(posedge clk);
      cnt_init = 32'hFFFF_FF00;
      cnt_load = 1'b1;
      @(posedge clk);
      cnt_load = 1'b0;
      @(negedge clk);
      start_run(16'd60);
      wait_done(1'b0, ncyc);
      chk("wrap_pass", 80'({o_pass, o_fail_mask}), 80'({1'b1, 14'h0}));
      chk("wrap_happened", 80'(blk_cnt < 32'h0000_1000), 80'(1));

      // Start while busy is ignored, then abort in step 5's dwell.
      start_run(16'd60);
      wait_step(4'd3);
      @(negedge clk);
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      chk("busy_start_ignored", 80'({o_step, o_gen_rst, o_busy}), 80'({4'd3, 1'b0, 1'b1}));
      wait_step(4'd5);
      repeat (30) @(negedge clk);
      i_abort = 1'b1;
      @(negedge clk);
      chk("abort_state", 80'({o_done, o_busy, o_pass, o_step}), 80'({1'b1, 1'b0, 1'b0, 4'd5}));
      chk("abort_mask", 80'(o_fail_mask), 80'h0);
      @(negedge clk);
      i_abort = 1'b0;
      @(negedge clk);
      chk("abort_hold", 80'({o_done, o_pass}), 80'({1'b1, 1'b0}));

      // Abort together with start in IDLE: abort wins.
      do_reset();
      i_start = 1'b1;
      i_abort = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      i_abort = 1'b0;
      chk("abort_start_idle", 80'({o_done, o_busy, o_pass}), 80'({1'b1, 1'b0, 1'b0}));

      // Reset mid-run returns everything to reset values.
      start_run(16'd60);
      wait_step(4'd4);
      @(negedge clk);
      i_rst = 1'b1;
      @(negedge clk);
      i_rst = 1'b0;
      check_reset_values("midrst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
